instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/instr_fetch_unit_fetch_fifo.sv | 81 ++++++++
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end: NOP filler, PC step,
// FSM encodings and buffer depth.
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam int          PC_STEP           = 4;
  localparam int          FETCH_FIFO_DEPTH  = 2;
  localparam int          I_MEM_LEN_DEFAULT = 1024;

  localparam logic [0:0]  FETCH_RUN  = 1'b0;
  localparam logic [0:0]  FETCH_HALT = 1'b1;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the memory-port, redirect and decode-handshake signals around the fetch unit.
interface instr_fetch_unit_if #(
  parameter int BUS_WIDTH = 32
) ();

  logic [BUS_WIDTH-1:0] imem_addr;
  logic [BUS_WIDTH-1:0] imem_rd_data;
  logic                 redirect_valid;
  logic [BUS_WIDTH-1:0] redirect_pc;
  logic [BUS_WIDTH-1:0] instr;
  logic [BUS_WIDTH-1:0] instr_pc;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 fetch_err;

  modport master (
    output imem_addr,
    input  imem_rd_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    output fetch_err
  );

  modport slave (
    input  imem_addr,
    output imem_rd_data,
    output redirect_valid,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    input  fetch_err
  );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small register-based FIFO with flush; the head is readable combinationally so
// decode sees the oldest fetched word without an extra cycle.
module fetch_fifo #(
  parameter int              WIDTH     = 64,
  parameter int              DEPTH     = 2,
  parameter int              CW        = $clog2(DEPTH + 1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [DEPTH-1:0] wr_en;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = do_push && !flush && (wr_ptr_reg == PW'(gi));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en[i]) begin
          mem_reg[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to the instruction port, tags the
// returning word with its PC and hands it to decode through a 2-entry buffer.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                   BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0,
  parameter int                   I_MEM_LEN = I_MEM_LEN_DEFAULT
) (
  input logic                clk,
  input logic                rstb,
  instr_fetch_unit_if.master bus
);

  localparam int                 CW       = $clog2(FETCH_FIFO_DEPTH + 1);
  localparam logic [BUS_WIDTH:0] PC_LIMIT = (BUS_WIDTH + 1)'(I_MEM_LEN) << 2;

  logic [BUS_WIDTH-1:0]   pc_reg;
  logic [BUS_WIDTH-1:0]   inflight_pc_reg;
  logic                   inflight_reg;
  logic                   fetch_err_reg;
  logic [0:0]             state_reg;

  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2*BUS_WIDTH-1:0] fifo_head;
  logic                   pop;
  logic                   push;
  logic                   redirect_take;
  logic                   issue_room;
  logic [CW:0]            occupancy;

  // The range compare is one bit wider so PCs near the top of the space cannot alias.
  function automatic logic pc_bad(input logic [BUS_WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= PC_LIMIT);
  endfunction

  assign pop           = !fifo_empty && bus.instr_ready;
  assign redirect_take = bus.redirect_valid && (state_reg == FETCH_RUN);
  assign push          = inflight_reg && !redirect_take;
  assign occupancy     = (CW + 1)'(fifo_count) + (CW + 1)'(inflight_reg);
  assign issue_room    = occupancy < ((CW + 1)'(FETCH_FIFO_DEPTH) + (CW + 1)'(pop));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= RESET_PC;
      fetch_err_reg   <= 1'b0;
      state_reg       <= FETCH_RUN;
    end else if (state_reg == FETCH_RUN) begin
      if (bus.redirect_valid) begin
        inflight_reg <= 1'b0;
        if (pc_bad(bus.redirect_pc)) begin
          fetch_err_reg <= 1'b1;
          state_reg     <= FETCH_HALT;
        end else begin
          pc_reg <= bus.redirect_pc;
        end
      end else if (issue_room) begin
        if (pc_bad(pc_reg)) begin
          inflight_reg  <= 1'b0;
          fetch_err_reg <= 1'b1;
          state_reg     <= FETCH_HALT;
        end else begin
          pc_reg          <= pc_reg + BUS_WIDTH'(PC_STEP);
          inflight_reg    <= 1'b1;
          inflight_pc_reg <= pc_reg;
        end
      end else begin
        inflight_reg <= 1'b0;
      end
    end else begin
      // HALT still lets an outstanding read land and the buffer drain.
      inflight_reg <= 1'b0;
    end
  end

  fetch_fifo #(
    .WIDTH     (2 * BUS_WIDTH),
    .DEPTH     (FETCH_FIFO_DEPTH),
    .CW        (CW),
    .RESET_VAL ({BUS_WIDTH'(NOP_INSTR), RESET_PC})
  ) u_fetch_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_take),
    .wr_data ({bus.imem_rd_data, inflight_pc_reg}),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The issue rule guarantees a capture never meets a full buffer without a pop.
  always_comb begin
    assert (!(push && fifo_full && !pop));
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.instr       = fifo_head[2*BUS_WIDTH-1:BUS_WIDTH];
  assign bus.instr_pc    = fifo_head[BUS_WIDTH-1:0];
  assign bus.instr_valid = !fifo_empty;
  assign bus.fetch_err   = fetch_err_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of per-cycle stimulus/expectations
// plus hand-written async-reset and out-of-range sequences.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rstb;
  logic rstb2;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [20];
  vec_t oor  [7];

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.BUS_WIDTH(32)) bus ();
  instr_fetch_unit_if #(.BUS_WIDTH(32)) bus2 ();

  instr_fetch_unit #(.BUS_WIDTH(32), .RESET_PC(32'h0), .I_MEM_LEN(64)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  instr_fetch_unit #(.BUS_WIDTH(32), .RESET_PC(32'h0), .I_MEM_LEN(4)) dut2 (
    .clk  (clk),
    .rstb (rstb2),
    .bus  (bus2)
  );

  // Memory word k holds 0x1000_0000 + k, one cycle read latency.
  always @(posedge clk) begin
    bus.imem_rd_data  <= 32'h1000_0000 + (bus.imem_addr >> 2);
    bus2.imem_rd_data <= 32'h1000_0000 + (bus2.imem_addr >> 2);
  end

  function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc,
                              input logic [31:0] addr, input logic err);
    vec_t t;
    t.ready = r; t.rv = rv; t.rpc = rpc;
    t.exp_valid = v; t.exp_pc = pc; t.exp_addr = addr; t.exp_err = err;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_step(input string tag, input vec_t v, input logic valid_a,
                            input logic [31:0] pc_a, input logic [31:0] instr_a,
                            input logic [31:0] addr_a, input logic err_a);
    $display("%s valid=%b pc=%h instr=%h addr=%h err=%b", tag, valid_a, pc_a, instr_a, addr_a, err_a);
    check({tag, " instr_valid"}, 32'(valid_a), 32'(v.exp_valid));
    check({tag, " imem_addr"}, addr_a, v.exp_addr);
    check({tag, " fetch_err"}, 32'(err_a), 32'(v.exp_err));
    if (v.exp_valid) begin
      check({tag, " instr_pc"}, pc_a, v.exp_pc);
      check({tag, " instr"}, instr_a, 32'h1000_0000 + (v.exp_pc >> 2));
    end
  endtask

  initial begin
    // Stream, redirect at 8 -> 0x40, 5-cycle stall, misaligned redirect, ignored redirect.
    vecs[0]  = mk(1, 0, 32'h00, 0, 32'h00, 32'h00, 0);
    vecs[1]  = mk(1, 0, 32'h00, 0, 32'h00, 32'h04, 0);
    vecs[2]  = mk(1, 0, 32'h00, 1, 32'h00, 32'h08, 0);
    vecs[3]  = mk(1, 0, 32'h00, 1, 32'h04, 32'h0C, 0);
    vecs[4]  = mk(1, 1, 32'h40, 1, 32'h08, 32'h10, 0);
    vecs[5]  = mk(1, 0, 32'h00, 0, 32'h00, 32'h40, 0);
    vecs[6]  = mk(1, 0, 32'h00, 0, 32'h00, 32'h44, 0);
    vecs[7]  = mk(1, 0, 32'h00, 1, 32'h40, 32'h48, 0);
    vecs[8]  = mk(0, 0, 32'h00, 1, 32'h44, 32'h4C, 0);
    vecs[9]  = mk(0, 0, 32'h00, 1, 32'h44, 32'h4C, 0);
    vecs[10] = mk(0, 0, 32'h00, 1, 32'h44, 32'h4C, 0);
    vecs[11] = mk(0, 0, 32'h00, 1, 32'h44, 32'h4C, 0);
    vecs[12] = mk(0, 0, 32'h00, 1, 32'h44, 32'h4C, 0);
    vecs[13] = mk(1, 0, 32'h00, 1, 32'h44, 32'h4C, 0);
    vecs[14] = mk(1, 0, 32'h00, 1, 32'h48, 32'h50, 0);
    vecs[15] = mk(1, 0, 32'h00, 1, 32'h4C, 32'h54, 0);
    vecs[16] = mk(1, 1, 32'h42, 1, 32'h50, 32'h58, 0);
    vecs[17] = mk(1, 1, 32'h00, 0, 32'h00, 32'h58, 1);
    vecs[18] = mk(1, 0, 32'h00, 0, 32'h00, 32'h58, 1);
    vecs[19] = mk(1, 0, 32'h00, 0, 32'h00, 32'h58, 1);

    // I_MEM_LEN=4: 0x0..0xC delivered, fault when 0x10 would issue, then drain.
    oor[0] = mk(1, 0, 0, 0, 32'h00, 32'h04, 0);
    oor[1] = mk(1, 0, 0, 1, 32'h00, 32'h08, 0);
    oor[2] = mk(1, 0, 0, 1, 32'h04, 32'h0C, 0);
    oor[3] = mk(1, 0, 0, 1, 32'h08, 32'h10, 0);
    oor[4] = mk(1, 0, 0, 1, 32'h0C, 32'h10, 1);
    oor[5] = mk(1, 0, 0, 0, 32'h00, 32'h10, 1);
    oor[6] = mk(1, 0, 0, 0, 32'h00, 32'h10, 1);

    rstb = 1'b0;
    rstb2 = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus2.instr_ready = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = '0;

    repeat (3) @(negedge clk);
    check("reset instr", bus.instr, NOP_INSTR);
    check("reset instr_pc", bus.instr_pc, 32'h0);
    check("reset instr_valid", 32'(bus.instr_valid), 32'h0);
    check("reset imem_addr", bus.imem_addr, 32'h0);
    check("reset fetch_err", 32'(bus.fetch_err), 32'h0);

    rstb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      bus.instr_ready    = vecs[i].ready;
      bus.redirect_valid = vecs[i].rv;
      bus.redirect_pc    = vecs[i].rpc;
      check_step($sformatf("step%0d", i), vecs[i], bus.instr_valid, bus.instr_pc,
                 bus.instr, bus.imem_addr, bus.fetch_err);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    // Sticky error clears only through reset.
    check("err still set", 32'(bus.fetch_err), 32'h1);
    rstb = 1'b0;
    #1;
    check("reset clears err", 32'(bus.fetch_err), 32'h0);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    rstb = 1'b1;

    // Fill both entries under backpressure, then reset between edges.
    repeat (3) @(posedge clk);
    #2;
    $display("pre-reset valid=%b pc=%h addr=%h", bus.instr_valid, bus.instr_pc, bus.imem_addr);
    check("prereset valid", 32'(bus.instr_valid), 32'h1);
    check("prereset instr_pc", bus.instr_pc, 32'h0);
    check("prereset imem_addr", bus.imem_addr, 32'h8);
    rstb = 1'b0;
    #1;
    $display("async reset valid=%b addr=%h", bus.instr_valid, bus.imem_addr);
    check("async valid", 32'(bus.instr_valid), 32'h0);
    check("async imem_addr", bus.imem_addr, 32'h0);
    check("async instr", bus.instr, NOP_INSTR);
    @(negedge clk);
    rstb = 1'b1;
    bus.instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("restart valid=%b pc=%h instr=%h", bus.instr_valid, bus.instr_pc, bus.instr);
    check("restart valid", 32'(bus.instr_valid), 32'h1);
    check("restart instr_pc", bus.instr_pc, 32'h0);
    check("restart instr", bus.instr, 32'h1000_0000);
    @(posedge clk);
    #1;
    check("restart next pc", bus.instr_pc, 32'h4);

    // Out-of-range fault on the small-memory instance.
    @(negedge clk);
    bus2.instr_ready = 1'b1;
    rstb2 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      check_step($sformatf("oor edge%0d", i + 1), oor[i], bus2.instr_valid, bus2.instr_pc,
                 bus2.instr, bus2.imem_addr, bus2.fetch_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
